// File: rtl/channel_scan_ctrl.sv
// Round-robin scan controller for a registered data mux: steps a select across the
// enabled channels with a programmable dwell and tags the delayed mux output.
module channel_scan_ctrl #(
  parameter int NUM_CH  = 5,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [NUM_CH-1:0]  ch_en,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  output logic               dout_valid,
  output logic [2:0]         dout_ch,
  output logic               frame_done,
  output logic               busy,
  output logic               fsm_state
);

  // start/stop are single-cycle request pulses with no acknowledge; dout_valid is a
  // qualifier only (no ready), marking the cycle whose mux output belongs to dout_ch.
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  logic [0:0]         state;
  logic [NUM_CH-1:0]  en_l;
  logic [DWELL_W-1:0] dwell_l;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_m1;
  logic               stop_pending;
  logic               last_dwell;
  logic [3:0]         nxt;
  logic               wrap;
  logic               stop_req;

  // Lowest enabled index in a mask; zero when the mask is empty.
  function automatic logic [2:0] first_en(input logic [NUM_CH-1:0] mask);
    logic [2:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) r = 3'(i);
    end
    return r;
  endfunction

  // {found, index} of the lowest enabled index strictly above cur.
  function automatic logic [3:0] next_above(input logic [NUM_CH-1:0] mask,
                                            input logic [2:0] cur);
    logic [3:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (3'(i) > cur)) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  // A latched dwell of zero counts as a single cycle per channel.
  always_comb begin
    dwell_m1   = '0;
    last_dwell = 1'b0;
    nxt        = '0;
    wrap       = 1'b0;
    stop_req   = 1'b0;
    if (dwell_l != '0) dwell_m1 = dwell_l - DWELL_W'(1);
    last_dwell = (cnt == dwell_m1);
    nxt        = next_above(en_l, sel);
    wrap       = last_dwell && !nxt[3];
    stop_req   = stop_pending || stop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sel          <= '0;
      cnt          <= '0;
      en_l         <= '0;
      dwell_l      <= '0;
      stop_pending <= 1'b0;
      dout_valid   <= 1'b0;
      dout_ch      <= '0;
      frame_done   <= 1'b0;
    end else begin
      // Output tags trail sel by one cycle to line up with the registered mux.
      dout_valid <= (state == SCAN);
      dout_ch    <= sel;
      frame_done <= (state == SCAN) && wrap;

      case (state)
        IDLE: begin
          sel <= '0;
          cnt <= '0;
          if (start && (ch_en != '0)) begin
            en_l         <= ch_en;
            dwell_l      <= dwell;
            sel          <= first_en(ch_en);
            stop_pending <= stop;
            state        <= SCAN;
          end
        end
        SCAN: begin
          if (stop) stop_pending <= 1'b1;
          if (!last_dwell) begin
            cnt <= cnt + DWELL_W'(1);
          end else if (nxt[3]) begin
            sel <= nxt[2:0];
            cnt <= '0;
          end else begin
            // Frame boundary: pick up fresh settings or end the scan.
            cnt     <= '0;
            en_l    <= ch_en;
            dwell_l <= dwell;
            if (stop_req || (ch_en == '0)) begin
              state        <= IDLE;
              sel          <= '0;
              stop_pending <= 1'b0;
            end else begin
              sel <= first_en(ch_en);
            end
          end
        end
        default: begin
          state <= IDLE;
          sel   <= '0;
        end
      endcase
    end
  end

  assign busy      = (state != IDLE) || dout_valid;
  assign fsm_state = state;

endmodule

// File: tb/tb_channel_scan_ctrl.sv
// Bench for channel_scan_ctrl: a frame-list reference model feeds a queue of expected
// samples that a separate monitor retires against the DUT outputs.
module tb_channel_scan_ctrl;

  localparam int NUM_CH  = 5;
  localparam int DWELL_W = 16;
  localparam int W       = 24;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic [NUM_CH-1:0]  ch_en = '0;
  logic [DWELL_W-1:0] dwell = '0;
  logic [2:0]         sel;
  logic               dout_valid;
  logic [2:0]         dout_ch;
  logic               frame_done;
  logic               busy;
  logic               fsm_state;

  channel_scan_ctrl #(.NUM_CH(NUM_CH), .DWELL_W(DWELL_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .ch_en      (ch_en),
    .dwell      (dwell),
    .sel        (sel),
    .dout_valid (dout_valid),
    .dout_ch    (dout_ch),
    .frame_done (frame_done),
    .busy       (busy),
    .fsm_state  (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];   // {cycle[19:0], ch[2:0], frame_done}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // A frame is the ordered list of sel values: each enabled channel, ascending,
  // repeated max(dwell,1) times. The scan consumes one entry per clock.
  int   frame_q[$];
  bit   scanning = 1'b0;
  bit   was_scan = 1'b0;
  bit   stop_flag = 1'b0;
  logic [2:0] exp_sel = '0;
  bit   exp_busy = 1'b0;

  task automatic build_frame(input logic [NUM_CH-1:0] m, input logic [DWELL_W-1:0] d);
    int reps;
    reps = (d == 0) ? 1 : int'(d);
    frame_q.delete();
    for (int c = 0; c < NUM_CH; c++) begin
      if (m[c]) for (int k = 0; k < reps; k++) frame_q.push_back(c);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    int s;
    if (rst) begin
      scanning  = 1'b0;
      was_scan  = 1'b0;
      stop_flag = 1'b0;
      frame_q.delete();
      exp_q.delete();
      exp_sel   = '0;
      exp_busy  = 1'b0;
    end else begin
      cyc++;
      was_scan = scanning;
      if (scanning) begin
        s = frame_q.pop_front();
        exp_q.push_back({20'(cyc), 3'(s), frame_q.size() == 0});
        if (stop) stop_flag = 1'b1;
        if (frame_q.size() == 0) begin
          if (stop_flag || (ch_en == '0)) begin
            scanning  = 1'b0;
            stop_flag = 1'b0;
          end else begin
            build_frame(ch_en, dwell);
          end
        end
      end else if (start && (ch_en != '0)) begin
        scanning  = 1'b1;
        stop_flag = stop;
        build_frame(ch_en, dwell);
      end
      exp_sel  = scanning ? 3'(frame_q[0]) : 3'd0;
      exp_busy = scanning || was_scan;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst) begin
      check("busy", 32'(busy), 32'(exp_busy));
      check("sel", 32'(sel), 32'(exp_sel));
      check("fsm_state", 32'(fsm_state), 32'(scanning));
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got dout_valid=1 ch=%0d expected no sample (cycle %0d)",
                   dout_ch, cyc);
        end else begin
          e = exp_q.pop_front();
          check("sample_cycle", 32'(cyc), 32'(e[23:4]));
          check("dout_ch", 32'(dout_ch), 32'(e[3:1]));
          check("frame_done", 32'(frame_done), 32'(e[0]));
        end
      end else begin
        check("frame_done_no_valid", 32'(frame_done), 32'd0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checks++;
          errors++;
          $display("FAIL missing_sample: got dout_valid=0 expected ch=%0d (cycle %0d)",
                   e[3:1], cyc);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input bit with_stop);
    @(negedge clk);
    start = 1'b1;
    stop  = with_stop;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_budget", 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sel"}, 32'(sel), 32'd0);
    check({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
    check({tag, "_dout_ch"}, 32'(dout_ch), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_state"}, 32'(fsm_state), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    cycles(2);

    // Full mask, dwell 2; clearing ch_en ends the scan at the next wrap.
    ch_en = 5'b11111; dwell = 16'd2;
    pulse_start(1'b0);
    cycles(30);
    ch_en = '0;
    wait_idle(60);

    // Sparse mask, dwell 1.
    ch_en = 5'b10010; dwell = 16'd1;
    pulse_start(1'b0);
    cycles(10);
    ch_en = '0;
    wait_idle(60);

    // Stop requested during channel 1 while the mask stays enabled.
    ch_en = 5'b00111; dwell = 16'd3;
    pulse_start(1'b0);
    cycles(3);
    pulse_stop();
    wait_idle(60);

    // Dwell 0 behaves as 1.
    ch_en = 5'b00011; dwell = 16'd0;
    pulse_start(1'b0);
    cycles(6);
    ch_en = '0;
    wait_idle(60);

    // Start with an empty mask is ignored.
    ch_en = '0; dwell = 16'd2;
    pulse_start(1'b0);
    cycles(3);

    // Mask change mid-frame only takes hold after the wrap.
    ch_en = 5'b11111; dwell = 16'd1;
    pulse_start(1'b0);
    cycles(2);
    ch_en = 5'b00100;
    cycles(10);
    ch_en = '0;
    wait_idle(60);

    // Start and stop together: exactly one frame.
    ch_en = 5'b01001; dwell = 16'd2;
    pulse_start(1'b1);
    wait_idle(60);

    // Single enabled channel, stop ignored while idle.
    ch_en = 5'b01000; dwell = 16'd2;
    pulse_stop();
    pulse_start(1'b0);
    cycles(8);
    ch_en = '0;
    wait_idle(60);

    // Asynchronous reset while channel 3 is selected.
    ch_en = 5'b11111; dwell = 16'd4;
    pulse_start(1'b0);
    cycles(13);
    check("pre_reset_sel", 32'(sel), 32'd3);
    #1 rst = 1'b1;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycles(5);
    check("post_reset_busy", 32'(busy), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0)
        ch_en = ($urandom_range(0, 5) == 0) ? '0 : NUM_CH'($urandom_range(1, 31));
      if ($urandom_range(0, 7) == 0) dwell = 16'($urandom_range(0, 3));
      start = ($urandom_range(0, 9) == 0);
      stop  = ($urandom_range(0, 24) == 0);
    end
    @(negedge clk);
    start = 1'b0; stop = 1'b0; ch_en = '0;
    wait_idle(400);
    cycles(2);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/channel_scan_ctrl.md
CHANNEL_SCAN_CTRL -- requirements
Module: channel_scan_ctrl

Interface
REQ-001 Parameter NUM_CH, default 5, SHALL set the number of scanned mux inputs (1..8).
REQ-002 Parameter DWELL_W, default 16, SHALL set the width of the dwell count.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 start  input  1  SHALL be a one-cycle pulse that begins a scan from IDLE.
REQ-006 stop  input  1  SHALL be a one-cycle pulse requesting scan end at the next frame boundary.
REQ-007 ch_en  input  NUM_CH  SHALL be the per-channel enable mask; bit i enables mux input i.
REQ-008 dwell  input  DWELL_W  SHALL be the number of consecutive sel cycles spent on each channel.
REQ-009 sel  output  3  SHALL be a registered select, driving the downstream registered 5:1 data mux.
REQ-010 dout_valid  output  1  SHALL mark cycles where the mux output holds a sample of an enabled channel.
REQ-011 dout_ch  output  3  SHALL be the channel index of the sample marked by dout_valid.
REQ-012 frame_done  output  1  SHALL pulse together with dout_valid on the last sample of each frame.
REQ-013 busy  output  1  SHALL be high whenever state is not IDLE or a sample is still in flight.

Function
REQ-014 The FSM SHALL have two states: IDLE and SCAN.
REQ-015 In IDLE, start=1 with ch_en!=0 SHALL: latch ch_en and dwell; load sel with the lowest enabled index; clear the dwell counter; enter SCAN next cycle.
REQ-016 In IDLE, start with ch_en==0 SHALL be ignored.
REQ-017 A latched dwell of 0 SHALL be treated as 1.
REQ-018 In SCAN, each cycle SHALL count one dwell cycle for the current sel.
REQ-019 When the count reaches latched dwell, sel SHALL advance to the next higher enabled index in the latched mask.
REQ-020 If no higher enabled index exists, sel SHALL wrap to the lowest enabled index.
REQ-021 When sel wraps, the dwell counter SHALL clear and ch_en and dwell SHALL be re-latched from the inputs.
REQ-022 If the re-latched ch_en is 0 at a wrap, the FSM SHALL go to IDLE.
REQ-023 With a single enabled channel, every dwell expiry SHALL be a wrap.
REQ-024 Mux latency compensation: dout_valid and dout_ch SHALL be the one-cycle-delayed copies of (state==SCAN) and sel, aligned with the mux's registered output.
REQ-025 frame_done SHALL be the one-cycle-delayed copy of "final dwell cycle of the highest enabled channel in the frame".
REQ-026 stop in SCAN SHALL set a sticky stop_pending flag.
REQ-027 At the next wrap with stop_pending set, the FSM SHALL enter IDLE instead of continuing, and stop_pending SHALL clear.
REQ-028 stop in IDLE SHALL be ignored.
REQ-029 start in SCAN SHALL be ignored.
REQ-030 If start and stop coincide in IDLE, the scan SHALL start, with stop_pending set.
REQ-031 In IDLE, sel SHALL hold 0.
REQ-032 The last in-flight sample SHALL still be flagged by dout_valid one cycle after leaving SCAN; busy SHALL stay high for that cycle.
REQ-033 Indices of NUM_CH or above SHALL never be driven on sel.

Reset
REQ-034 rst=1 SHALL immediately, without waiting for clk, force:
- state=IDLE, sel=0, dout_valid=0, dout_ch=0, frame_done=0, busy=0;
- stop_pending=0, dwell counter=0, latched ch_en=0, latched dwell=0.
REQ-035 rst asserted during SCAN SHALL abort the scan with no further valid or frame_done pulses.
REQ-036 After rst deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-037 Basic scan: ch_en=5'b11111, dwell=2, start → sel sequence 0,0,1,1,2,2,3,3,4,4,0…; dout_ch follows one cycle later with dout_valid=1; frame_done on the second ch-4 sample.
REQ-038 Sparse mask: ch_en=5'b10010, dwell=1 → sel 1,4,1,4…; frame_done with every ch-4 sample.
REQ-039 Stop mid-frame: ch_en=5'b00111, dwell=3, stop during ch-1 → frame completes through ch 2; IDLE; dout_valid low two cycles after the last ch-2 sel cycle; busy drops with it.
REQ-040 Edge inputs:
- dwell=0 behaves as dwell=1;
- start with ch_en=0 leaves busy=0;
- ch_en changed mid-frame takes effect only after the wrap.
REQ-041 Reset mid-scan: rst asserted asynchronously during ch 3 → all outputs 0 before the next clk edge; after release, no activity until start.
